// File: rtl/fifo_drain.sv
// Parallel-in/serial-out drain: one load captures DEPTH words, emitted oldest-first one per beat.
// First word is valid the cycle after load; under back-pressure the head word and count hold steady.
module fifo_drain #(
  parameter  int DEPTH = 8,
  parameter  int BITS  = 64,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DEPTH*BITS-1:0] load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic                  out_last,
  output logic [CW-1:0]         count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]            state;
  logic [DEPTH*BITS-1:0] store;
  logic [DEPTH*BITS-1:0] shifted;
  logic [CW-1:0]         cnt;
  logic                  load_fire;
  logic                  beat;

  // Shift toward word 0 with zero-fill so an emptied buffer reads back as 0.
  if (DEPTH == 1) begin : g_one
    assign shifted = '0;
  end else begin : g_shift
    assign shifted = {{BITS{1'b0}}, store[DEPTH*BITS-1:BITS]};
  end

  assign count      = cnt;
  assign out_valid  = (state == DRAIN);
  assign out_last   = out_valid & (cnt == CW'(1));
  assign out_data   = store[BITS-1:0];
  // A new row may land on the final beat so rows stream without a bubble.
  assign load_ready = ~rst & ((state == IDLE) | (out_last & out_ready));
  assign load_fire  = load_valid & load_ready;
  assign beat       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      store <= '0;
      cnt   <= '0;
    end else if (load_fire) begin
      state <= DRAIN;
      store <= load_data;
      cnt   <= CW'(DEPTH);
    end else if (beat) begin
      store <= shifted;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) state <= IDLE;
    end
  end

endmodule
